// File: rtl/bp_common_pkg.sv
// Shared types for the page-table walker: Sv39 PTE layout, page offset width
// and walker FSM states.
package bp_common_pkg;

  localparam int page_offset_width_gp = 12;

  typedef struct packed {
    logic [9:0]  rsvd;
    logic [43:0] ppn;
    logic [1:0]  rsw;
    logic        d;
    logic        a;
    logic        g;
    logic        u;
    logic        x;
    logic        w;
    logic        r;
    logic        v;
  } bp_sv39_pte_s;

  typedef enum logic [2:0] {
    e_idle, e_send, e_wait, e_fill, e_fault, e_drain
  } bp_walker_state_e;

endpackage

// File: rtl/bp_pte_decode.sv
// Combinational PTE decode: validity, leaf/superpage alignment and the
// superpage-expanded TLB fill entry for the current walk level.
module bp_pte_decode
  import bp_common_pkg::*;
#(
  parameter int vtag_width_p       = 27,
  parameter int ptag_width_p       = 28,
  parameter int page_idx_width_p   = 9,
  parameter int pte_width_p        = 64,
  parameter int lvl_width_p        = 2
) (
  input  logic [pte_width_p-1:0]    pte_i,
  input  logic [lvl_width_p-1:0]    level_i,
  input  logic [vtag_width_p-1:0]   vtag_i,
  output logic                      invalid_o,
  output logic                      leaf_o,
  output logic                      misaligned_o,
  output logic [ptag_width_p-1:0]   ppn_o,
  output logic [ptag_width_p-1:0]   ptag_o,
  output logic [ptag_width_p+3:0]   entry_o
);

  bp_sv39_pte_s            pte_s;
  logic [31:0]             shamt;
  logic [ptag_width_p-1:0] mask;
  logic                    unused;

  assign pte_s = $bits(bp_sv39_pte_s)'(pte_i);
  assign ppn_o = pte_s.ppn[ptag_width_p-1:0];

  // Low PPN bits covered by the superpage at this level.
  assign shamt = 32'(level_i) * 32'(page_idx_width_p);
  assign mask  = ~({ptag_width_p{1'b1}} << shamt);

  assign invalid_o    = ~pte_s.v | (pte_s.w & ~pte_s.r);
  assign leaf_o       = pte_s.r | pte_s.x;
  assign misaligned_o = leaf_o & (|(ppn_o & mask));

  assign ptag_o  = (ppn_o & ~mask) | (ptag_width_p'(vtag_i) & mask);
  assign entry_o = {ptag_o, pte_s.u, pte_s.x, pte_s.w, pte_s.r};

  assign unused = ^{pte_s.rsvd, pte_s.ppn, pte_s.rsw, pte_s.d, pte_s.a, pte_s.g};

endmodule

// File: rtl/bp_tlb_walker.sv
// Hardware page-table walker: one PTE read per level, single outstanding
// request, single-cycle TLB fill on a leaf or fault pulse on a bad PTE.
module bp_tlb_walker
  import bp_common_pkg::*;
#(
  parameter  int vtag_width_p       = 27,
  parameter  int ptag_width_p       = 28,
  parameter  int page_idx_width_p   = 9,
  parameter  int page_table_depth_p = 3,
  parameter  int pte_width_p        = 64,
  parameter  int paddr_width_p      = 40,
  localparam int entry_width_lp     = ptag_width_p + 4
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      flush_i,
  input  logic [ptag_width_p-1:0]   base_ppn_i,
  input  logic                      miss_v_i,
  input  logic [vtag_width_p-1:0]   miss_vtag_i,
  output logic                      miss_ready_o,
  output logic                      mem_v_o,
  output logic [paddr_width_p-1:0]  mem_addr_o,
  input  logic                      mem_ready_i,
  input  logic                      mem_data_v_i,
  input  logic [pte_width_p-1:0]    mem_data_i,
  output logic                      fill_v_o,
  output logic [vtag_width_p-1:0]   fill_vtag_o,
  output logic [entry_width_lp-1:0] fill_entry_o,
  output logic                      fault_v_o,
  output logic                      busy_o
);

  localparam int lvl_width_lp  = (page_table_depth_p > 1) ? $clog2(page_table_depth_p) : 1;
  localparam int full_width_lp = ptag_width_p + page_offset_width_gp;

  bp_walker_state_e state_r, state_n;

  logic [vtag_width_p-1:0]     vtag_r;
  logic [ptag_width_p-1:0]     ppn_r;
  logic [lvl_width_lp-1:0]     level_r;
  logic [entry_width_lp-1:0]   entry_r;
  logic [page_idx_width_p-1:0] idx;
  logic [full_width_lp-1:0]    addr_full;

  logic                      dec_invalid, dec_leaf, dec_misaligned;
  logic [ptag_width_p-1:0]   dec_ppn, dec_ptag;
  logic [entry_width_lp-1:0] dec_entry;

  bp_pte_decode #(
    .vtag_width_p     (vtag_width_p),
    .ptag_width_p     (ptag_width_p),
    .page_idx_width_p (page_idx_width_p),
    .pte_width_p      (pte_width_p),
    .lvl_width_p      (lvl_width_lp)
  ) u_decode (
    .pte_i        (mem_data_i),
    .level_i      (level_r),
    .vtag_i       (vtag_r),
    .invalid_o    (dec_invalid),
    .leaf_o       (dec_leaf),
    .misaligned_o (dec_misaligned),
    .ppn_o        (dec_ppn),
    .ptag_o       (dec_ptag),
    .entry_o      (dec_entry)
  );

  assign idx       = vtag_r[level_r*page_idx_width_p +: page_idx_width_p];
  assign addr_full = {ppn_r, {page_offset_width_gp{1'b0}}}
                   + full_width_lp'({idx, 3'b000});

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= e_idle;
    else            state_r <= state_n;
  end

  always_comb begin
    state_n   = state_r;
    mem_v_o   = 1'b0;
    fill_v_o  = 1'b0;
    fault_v_o = 1'b0;
    case (state_r)
      e_idle:  if (miss_v_i && !flush_i) state_n = e_send;
      e_send: begin
        mem_v_o = 1'b1;
        if (flush_i)          state_n = mem_ready_i ? e_drain : e_idle;
        else if (mem_ready_i) state_n = e_wait;
      end
      e_wait: begin
        // A response coinciding with the flush is the one we would drain.
        if (flush_i)                          state_n = mem_data_v_i ? e_idle : e_drain;
        else if (mem_data_v_i) begin
          if (dec_invalid || dec_misaligned)  state_n = e_fault;
          else if (dec_leaf)                  state_n = e_fill;
          else if (level_r == '0)             state_n = e_fault;
          else                                state_n = e_send;
        end
      end
      e_fill: begin
        fill_v_o = ~flush_i;
        state_n  = e_idle;
      end
      e_fault: begin
        fault_v_o = ~flush_i;
        state_n   = e_idle;
      end
      e_drain: if (mem_data_v_i) state_n = e_idle;
      default: state_n = e_idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      vtag_r  <= '0;
      ppn_r   <= '0;
      level_r <= '0;
      entry_r <= '0;
    end else begin
      if (state_r == e_idle && state_n == e_send) begin
        vtag_r  <= miss_vtag_i;
        ppn_r   <= base_ppn_i;
        level_r <= lvl_width_lp'(page_table_depth_p - 1);
      end
      if (state_r == e_wait && state_n == e_send) begin
        ppn_r   <= dec_ppn;
        level_r <= level_r - 1'b1;
      end
      if (state_n == e_fill) entry_r <= dec_entry;
    end
  end

  assign miss_ready_o = (state_r == e_idle);
  assign busy_o       = (state_r != e_idle);
  assign mem_addr_o   = mem_v_o  ? paddr_width_p'(addr_full) : '0;
  assign fill_vtag_o  = fill_v_o ? vtag_r  : '0;
  assign fill_entry_o = fill_v_o ? entry_r : '0;

endmodule

// File: tb/tb_bp_tlb_walker.sv
// Scoreboard bench for bp_tlb_walker: expected addresses/fills/faults queued
// at stimulus time, popped when the walker produces them.
module tb_bp_tlb_walker;

  logic        clk = 1'b0;
  logic        reset_n_i;
  logic        flush_i;
  logic [27:0] base_ppn_i;
  logic        miss_v_i;
  logic [26:0] miss_vtag_i;
  logic        miss_ready_o;
  logic        mem_v_o;
  logic [39:0] mem_addr_o;
  logic        mem_ready_i;
  logic        mem_data_v_i;
  logic [63:0] mem_data_i;
  logic        fill_v_o;
  logic [26:0] fill_vtag_o;
  logic [31:0] fill_entry_o;
  logic        fault_v_o;
  logic        busy_o;

  bp_tlb_walker dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n_i),
    .flush_i      (flush_i),
    .base_ppn_i   (base_ppn_i),
    .miss_v_i     (miss_v_i),
    .miss_vtag_i  (miss_vtag_i),
    .miss_ready_o (miss_ready_o),
    .mem_v_o      (mem_v_o),
    .mem_addr_o   (mem_addr_o),
    .mem_ready_i  (mem_ready_i),
    .mem_data_v_i (mem_data_v_i),
    .mem_data_i   (mem_data_i),
    .fill_v_o     (fill_v_o),
    .fill_vtag_o  (fill_vtag_o),
    .fill_entry_o (fill_entry_o),
    .fault_v_o    (fault_v_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [26:0] vtag;
    logic [31:0] entry;
  } fill_exp_t;

  fill_exp_t   fill_q[$];
  logic [39:0] addr_q[$];
  logic [63:0] pte_q[$];
  int          fault_exp;

  int n_chk, n_fail;
  int cyc, fill_cyc, n_req;
  int resp_delay, resp_wait, stall;
  bit resp_pend, seen_evt, stall_seen;
  logic [39:0] stall_addr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // flags = {u, x, w, r, v}
  function automatic logic [63:0] pte(input logic [27:0] ppn, input logic [4:0] flags);
    return {26'b0, ppn, 5'b0, flags};
  endfunction

  // One cycle: monitor outputs at negedge, then drive memory side for next edge.
  task automatic tick();
    fill_exp_t fe;
    @(negedge clk);
    cyc++;
    if (fill_v_o) begin
      seen_evt = 1;
      fill_cyc = cyc;
      chk("fill_expected", fill_q.size() != 0, 1);
      if (fill_q.size() != 0) begin
        fe = fill_q.pop_front();
        chk("fill_vtag", fill_vtag_o, fe.vtag);
        chk("fill_entry", fill_entry_o, fe.entry);
      end
    end
    if (fault_v_o) begin
      seen_evt = 1;
      chk("fault_expected", fault_exp > 0, 1);
      if (fault_exp > 0) fault_exp--;
      chk("fault_nofill", fill_v_o, 0);
    end
    mem_data_v_i = 1'b0;
    if (resp_pend) begin
      if (resp_wait == 0) begin
        resp_pend    = 0;
        mem_data_v_i = 1'b1;
        mem_data_i   = (pte_q.size() != 0) ? pte_q.pop_front() : 64'h0;
      end else resp_wait--;
    end
    if (mem_v_o && stall > 0) begin
      if (stall_seen) chk("bp_addr_stable", mem_addr_o, stall_addr);
      else begin stall_seen = 1; stall_addr = mem_addr_o; end
      stall--;
      mem_ready_i = 1'b0;
    end else mem_ready_i = 1'b1;
    if (mem_v_o && mem_ready_i) begin
      n_req++;
      chk("req_expected", addr_q.size() != 0, 1);
      if (addr_q.size() != 0) chk("mem_addr", mem_addr_o, addr_q.pop_front());
      resp_pend = 1;
      resp_wait = resp_delay;
    end
  endtask

  task automatic do_miss(input logic [26:0] vtag, input logic [27:0] base);
    seen_evt    = 0;
    miss_v_i    = 1'b1;
    miss_vtag_i = vtag;
    base_ppn_i  = base;
    cyc         = 0;
    tick();
    miss_v_i    = 1'b0;
  endtask

  task automatic walk(input logic [26:0] vtag, input logic [27:0] base);
    do_miss(vtag, base);
    for (int i = 0; i < 50 && !seen_evt; i++) tick();
    chk("walk_done", seen_evt, 1);
    tick();
    chk("ready_after", miss_ready_o, 1);
  endtask

  task automatic push_3lvl();
    addr_q.push_back(40'h100008); pte_q.push_back(pte(28'h200, 5'b00001));
    addr_q.push_back(40'h200008); pte_q.push_back(pte(28'h300, 5'b00001));
    addr_q.push_back(40'h300008); pte_q.push_back(pte(28'hABCDE, 5'b00111));
    fill_q.push_back('{vtag: 27'h0040201, entry: {28'hABCDE, 4'b0011}});
  endtask

  initial begin
    int n0;
    n_chk = 0; n_fail = 0; n_req = 0; fault_exp = 0;
    resp_delay = 0; resp_wait = 0; resp_pend = 0; stall = 0; stall_seen = 0;
    reset_n_i = 1'b0; flush_i = 1'b0; base_ppn_i = '0; miss_v_i = 1'b0;
    miss_vtag_i = '0; mem_ready_i = 1'b1; mem_data_v_i = 1'b0; mem_data_i = '0;
    tick(); tick();
    chk("rst_miss_ready", miss_ready_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_mem_v", mem_v_o, 0);
    chk("rst_fill_v", fill_v_o, 0);
    chk("rst_fault_v", fault_v_o, 0);
    reset_n_i = 1'b1;
    tick();

    // full 3-level walk
    push_3lvl();
    walk(27'h0040201, 28'h100);
    chk("fill_latency", fill_cyc, 7);

    // gigapage leaf at level 2
    addr_q.push_back(40'h100000); pte_q.push_back(pte(28'h40000, 5'b01011));
    fill_q.push_back('{vtag: 27'h0012345, entry: {28'h52345, 4'b0101}});
    walk(27'h0012345, 28'h100);

    // invalid PTE
    addr_q.push_back(40'h100000); pte_q.push_back(64'h0); fault_exp++;
    walk(27'h0012345, 28'h100);

    // W without R
    addr_q.push_back(40'h100000); pte_q.push_back(pte(28'h40000, 5'b00101)); fault_exp++;
    walk(27'h0012345, 28'h100);

    // misaligned gigapage
    addr_q.push_back(40'h100000); pte_q.push_back(pte(28'h40001, 5'b00011)); fault_exp++;
    walk(27'h0012345, 28'h100);

    // non-leaf at level 0
    addr_q.push_back(40'h100008); pte_q.push_back(pte(28'h200, 5'b00001));
    addr_q.push_back(40'h200008); pte_q.push_back(pte(28'h300, 5'b00001));
    addr_q.push_back(40'h300008); pte_q.push_back(pte(28'h400, 5'b00001));
    fault_exp++;
    walk(27'h0040201, 28'h100);

    // flush while waiting: flush at cycle 2, response at cycle 5
    addr_q.push_back(40'h100008); pte_q.push_back(pte(28'h200, 5'b00001));
    resp_delay = 3;
    do_miss(27'h0040201, 28'h100);
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("flush_busy_c3", busy_o, 1);
    tick(); chk("flush_busy_c4", busy_o, 1);
    tick(); chk("flush_busy_c5", busy_o, 1);
    tick(); chk("flush_ready_c6", miss_ready_o, 1);
    resp_delay = 0;
    push_3lvl();
    walk(27'h0040201, 28'h100);

    // backpressure: ready low 4 cycles
    stall = 4; stall_seen = 0; n0 = n_req;
    addr_q.push_back(40'h100000); pte_q.push_back(pte(28'h40000, 5'b01011));
    fill_q.push_back('{vtag: 27'h0012345, entry: {28'h52345, 4'b0101}});
    walk(27'h0012345, 28'h100);
    chk("bp_one_req", n_req - n0, 1);
    chk("bp_stall_used", stall, 0);

    // async reset mid-walk
    addr_q.push_back(40'h100000); pte_q.push_back(pte(28'h40000, 5'b01011));
    resp_delay = 5;
    do_miss(27'h0012345, 28'h100);
    tick(); tick();
    chk("pre_rst_busy", busy_o, 1);
    #2 reset_n_i = 1'b0;
    #1;
    chk("arst_busy", busy_o, 0);
    chk("arst_ready", miss_ready_o, 1);
    chk("arst_mem_v", mem_v_o, 0);
    resp_pend = 0; resp_delay = 0;
    addr_q.delete(); pte_q.delete();
    tick();
    reset_n_i = 1'b1;
    tick();
    mem_data_v_i = 1'b1;
    mem_data_i   = pte(28'h40000, 5'b01011);
    tick();
    tick(); tick();
    chk("late_resp_busy", busy_o, 0);
    chk("late_resp_ready", miss_ready_o, 1);

    chk("addr_q_empty", addr_q.size(), 0);
    chk("pte_q_empty", pte_q.size(), 0);
    chk("fill_q_empty", fill_q.size(), 0);
    chk("fault_exp_zero", fault_exp, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_tlb_walker.md
Name: bp_tlb_walker

Overview:
- Hardware page-table walker that services TLB misses.
- Accepts a missing vtag from the TLB, issues one PTE read per level to the memory side, and decodes each returned PTE.
- On a leaf it drives a single-cycle fill write into the TLB. On an invalid PTE it raises a fault.
- Sits directly downstream of the TLB miss output and directly upstream of the TLB write port.

Parameters:
- vtag_width_p, 27, virtual page number width (depth × idx width)
- ptag_width_p, 28, physical page number width
- page_idx_width_p, 9, VPN bits consumed per level
- page_table_depth_p, 3, number of levels
- pte_width_p, 64, PTE width
- paddr_width_p, 40, memory request address width
- entry_width_lp (local), ptag_width_p+4, fill entry {ptag, u, x, w, r}

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- flush_i  in  1  abort walk / discard fill
- base_ppn_i  in  ptag_width_p  root table PPN (satp), sampled at miss accept
- miss_v_i  in  1  miss request valid
- miss_vtag_i  in  vtag_width_p  missing VPN
- miss_ready_o  out  1  walker idle, can accept
- mem_v_o  out  1  PTE read request valid
- mem_addr_o  out  paddr_width_p  PTE address
- mem_ready_i  in  1  memory accepts request
- mem_data_v_i  in  1  PTE response valid
- mem_data_i  in  pte_width_p  PTE
- fill_v_o  out  1  TLB write strobe
- fill_vtag_o  out  vtag_width_p  vtag to write
- fill_entry_o  out  entry_width_lp  entry to write
- fault_v_o  out  1  page fault pulse
- busy_o  out  1  walk in progress

Behaviour:
- Reset is asynchronous, active-low. All state regs clear, FSM goes to IDLE, all outputs are 0 except miss_ready_o = 1.
- IDLE:
  - miss_ready_o = 1.
  - miss_v_i & ~flush_i latches vtag and base_ppn, sets level = depth-1, and moves to SEND.
  - Miss and flush in the same cycle: the miss is ignored.
- SEND:
  - mem_v_o = 1, mem_addr_o = {ppn_r, 12'b0} + idx×8, zero-extended/truncated to paddr_width_p.
  - idx = vtag_r[level×page_idx_width_p +: page_idx_width_p].
  - mem_ready_i moves to WAIT. Address is stable while mem_v_o is high.
- WAIT:
  - On mem_data_v_i, decode PTE: V = bit0, R = 1, W = 2, X = 3, U = 4, PPN = bits[10 +: ptag_width_p].
  - Invalid (~V or (W & ~R)) → FAULT.
  - Leaf (R|X) with level > 0 and PPN low level×idx bits ≠ 0 → FAULT (misaligned superpage).
  - Leaf otherwise → FILL. The ptag is PPN with its low level×idx bits replaced by the vtag's low bits (superpage expansion).
  - Non-leaf at level 0 → FAULT.
  - Non-leaf at level > 0 → ppn_r = PPN, level -= 1, go to SEND.
  - Responses arriving in IDLE/SEND/FILL/FAULT are ignored; the single-outstanding protocol guarantees none.
- FILL: fill_v_o = 1 for exactly one cycle with fill_vtag_o = vtag_r, then go to IDLE.
- FAULT: fault_v_o = 1 for exactly one cycle, no fill, then go to IDLE.
- flush_i:
  - In SEND before acceptance: go to IDLE.
  - In SEND with mem_ready_i in the same cycle, or in WAIT: go to DRAIN.
  - In FILL/FAULT: suppress the pulse, go to IDLE.
- DRAIN: wait for mem_data_v_i, discard it, go to IDLE. flush_i in DRAIN has no extra effect.
- busy_o = (state ≠ IDLE).
- Latency of a full 3-level walk with zero-wait memory:
  - miss accept at cycle 0, SEND at 1, responses at 2/4/6.
  - fill_v_o at cycle 7.
- At most one walk in flight; at most one memory request outstanding.

Decomposition:
- Shared package (bp_common_pkg):
  - PTE struct bp_sv39_pte_s {ppn, rsw, d, a, g, u, x, w, r, v}.
  - Page offset width constant (12).
  - Walker state enum (e_idle, e_send, e_wait, e_fill, e_fault, e_drain).
- One natural sub-module: bp_pte_decode, combinational. Inputs are PTE, level and vtag; outputs are invalid, leaf, misaligned, and expanded ptag/entry. It is verified stand-alone.

Test Plan:
- 3-level walk:
  - Stimulus: base_ppn = 0x100, vtag = 0x0040201 (idx 1,1,1). Returned PTEs are non-leaf PPN 0x200, non-leaf PPN 0x300, then leaf PPN 0xABCDE with R|W|V.
  - Response: addresses 0x100008, 0x200008, 0x300008; then fill_v_o one cycle with entry ptag 0xABCDE, r = w = 1.
- Gigapage:
  - Stimulus: level-2 leaf PPN 0x40000, vtag = 0x0012345.
  - Response: single request; fill ptag = 0x40000 | 0x12345 = 0x52345.
- Faults:
  - Level-2 PTE with V = 0 → fault_v_o one cycle, no fill_v_o, miss_ready_o = 1 next cycle.
  - Level-2 leaf with PPN = 0x40001 → fault (misaligned).
  - Level-0 non-leaf → fault.
- Flush in WAIT:
  - Stimulus: flush_i at cycle 2, response at cycle 5.
  - Response: no fill, busy_o = 1 through cycle 5, miss_ready_o = 1 at cycle 6. A new miss at cycle 6 walks correctly.
- Backpressure:
  - Stimulus: mem_ready_i held low 4 cycles.
  - Response: mem_v_o and mem_addr_o stable for those cycles; exactly one request is counted.
- Async reset mid-walk:
  - Stimulus: drop reset_n_i in WAIT, between clock edges.
  - Response: outputs go to reset values immediately without a clock edge; a late response after release is ignored.
